// File: rtl/hp_encode_if.sv
// hp_encode_if: request/result handshake bundle for the binary16 encoder
interface hp_encode_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  cls;
  logic        sign;
  logic [15:0] mag;
  logic [3:0]  scale;
  logic [8:0]  payload;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] f;
  logic        snan;
  logic        qnan;
  logic        infinity;
  logic        zero;
  logic        subnormal;
  logic        normal;
  modport master (
    output in_valid, cls, sign, mag, scale, payload, out_ready,
    input  in_ready, out_valid, f, snan, qnan, infinity, zero, subnormal, normal
  );
  modport slave (
    input  in_valid, cls, sign, mag, scale, payload, out_ready,
    output in_ready, out_valid, f, snan, qnan, infinity, zero, subnormal, normal
  );
endinterface

// File: rtl/hp_encode.sv
// hp_encode: scaled integer / special class to IEEE binary16 with round-to-nearest-even
module hp_encode (
  input logic      clk,
  input logic      rst,
  hp_encode_if.slave bus
);
  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;
  state_t      state_q, state_d;
  logic [15:0] mant_q, mant_d;
  logic [4:0]  e_q, e_d;
  logic        sign_q, sign_d;
  logic [15:0] f_q, f_d;
  logic [5:0]  flags_q, flags_d;
  logic [14:0] spec_bits;
  logic [5:0]  spec_fl;
  logic [4:0]  e_f;
  logic [14:0] base, rnd;
  logic        inc;
  assign bus.in_ready  = (state_q == IDLE) & ~rst;
  assign bus.out_valid = state_q == DONE;
  assign bus.f         = f_q;
  assign {bus.snan, bus.qnan, bus.infinity, bus.zero, bus.subnormal, bus.normal} = flags_q;
  assign e_f  = mant_q[15] ? e_q : 5'd0;
  assign base = {e_f, mant_q[14:5]};
  assign inc  = mant_q[4] & ((|mant_q[3:0]) | mant_q[5]);
  assign rnd  = base + {14'd0, inc};
  // encoding and flag set for requests that bypass normalisation
  always_comb begin
    spec_bits = 15'h7E00;
    spec_fl   = 6'b010000;
    case (bus.cls)
      3'd0, 3'd1: begin spec_bits = 15'h0000; spec_fl = 6'b000100; end
      3'd2:       begin spec_bits = 15'h7C00; spec_fl = 6'b001000; end
      3'd3:       begin spec_bits = {6'h3F, bus.payload}; spec_fl = 6'b010000; end
      3'd4:       begin spec_bits = {6'h3E, bus.payload == 9'd0 ? 9'h001 : bus.payload}; spec_fl = 6'b100000; end
      default:    ;
    endcase
  end
  // next state: accept, shift-normalise one bit per cycle, round, hold result
  always_comb begin
    state_d = state_q;
    mant_d  = mant_q;
    e_d     = e_q;
    sign_d  = sign_q;
    f_d     = f_q;
    flags_d = flags_q;
    case (state_q)
      IDLE: if (bus.in_valid) begin
        sign_d = bus.sign;
        if (bus.cls == 3'd0 && bus.mag != 16'd0) begin
          mant_d  = bus.mag;
          e_d     = 5'd30 - {1'b0, bus.scale};
          state_d = NORM;
        end else begin
          f_d     = {bus.sign, spec_bits};
          flags_d = spec_fl;
          state_d = DONE;
        end
      end
      NORM: if (mant_q[15] || e_q == 5'd1) state_d = ROUND;
      else begin
        mant_d = {mant_q[14:0], 1'b0};
        e_d    = e_q - 5'd1;
      end
      ROUND: begin
        f_d     = {sign_q, rnd};
        flags_d = rnd[14:10] == 5'h1F ? 6'b001000 : rnd[14:10] == 5'd0 ? 6'b000010 : 6'b000001;
        state_d = DONE;
      end
      DONE: if (bus.out_ready) begin
        flags_d = 6'd0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state register; reset drops any request in flight and clears the result
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mant_q  <= 16'd0;
      e_q     <= 5'd0;
      sign_q  <= 1'b0;
      f_q     <= 16'd0;
      flags_q <= 6'd0;
    end else begin
      state_q <= state_d;
      mant_q  <= mant_d;
      e_q     <= e_d;
      sign_q  <= sign_d;
      f_q     <= f_d;
      flags_q <= flags_d;
    end
  end
endmodule

// File: doc/hp_encode.md
HP_ENCODE -- requirements
Module: hp_encode

Interface
REQ-001 The block SHALL use these ports (name  direction  width  meaning), clock and reset first:
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  request present.
REQ-005 in_ready  output  1  block accepts request this cycle.
REQ-006 cls  input  3  requested class: 0 finite, 1 zero, 2 infinity, 3 qnan, 4 snan, 5-7 reserved.
REQ-007 sign  input  1  sign of result.
REQ-008 mag  input  16  unsigned integer magnitude (cls=0 only).
REQ-009 scale  input  4  value = mag x 2^-scale (cls=0 only).
REQ-010 payload  input  9  NaN payload, fraction bits [8:0] (cls=3,4 only).
REQ-011 out_valid  output  1  result held on f and flags.
REQ-012 out_ready  input  1  consumer takes result.
REQ-013 f  output  16  IEEE 754 binary16 result.
REQ-014 snan, qnan, infinity, zero, subnormal, normal  output  1 each  class of f; exactly one high while out_valid=1.

Function
REQ-015 States SHALL be IDLE, NORM, ROUND, DONE; in_ready = (state==IDLE) & ~rst.
REQ-016 Accept SHALL occur on the edge where in_valid & in_ready; inputs SHALL be captured then and ignored afterwards.
REQ-017 On accept, cls=1 or (cls=0 & mag=0) SHALL go to DONE with f={sign,15'h0}, zero=1.
REQ-018 On accept, cls=2 SHALL go to DONE with f={sign,5'h1F,10'h0}, infinity=1.
REQ-019 On accept, cls=3 SHALL go to DONE with f={sign,5'h1F,1'b1,payload}, qnan=1.
REQ-020 On accept, cls=4 SHALL go to DONE with f={sign,5'h1F,1'b0,payload'}, payload'=payload if nonzero else 9'h001, snan=1.
REQ-021 On accept, cls=5..7 SHALL go to DONE with f={sign,5'h1F,10'h200}, qnan=1.
REQ-022 On accept with cls=0 & mag!=0: mant<=mag, E<=30-scale (5-bit, range 15..30), go to NORM.
REQ-023 NORM: if mant[15]=1 or E=1 go to ROUND; else mant<=mant<<1, E<=E-1, stay (one shift per cycle, max 15).
REQ-024 ROUND: base={e_f, mant[14:5]}, e_f=E if mant[15] else 0; guard=mant[4], sticky=|mant[3:0].
REQ-025 Rounding SHALL be round-to-nearest-even: add 1 to base iff guard & (sticky | mant[5]); carry propagates into the exponent field.
REQ-026 ROUND SHALL register f={sign, rounded 15 bits} and go to DONE; flags from f: exp 5'h1F -> infinity; exp 0 -> subnormal (fraction never 0 here); else normal.
REQ-027 Carry to exp 5'h1F SHALL yield infinity (0x7C00/0xFC00); subnormal 0x3FF carry SHALL yield min normal 0x0400.
REQ-028 Latency, accept edge to first out_valid cycle: 1 cycle for non-finite/zero; 3+shift count for finite nonzero.
REQ-029 DONE: out_valid=1, f and flags stable; on edge with out_ready=1 go to IDLE, out_valid and all flags 0, f holds its value.
REQ-030 in_ready SHALL be 0 in NORM, ROUND, DONE; no accept in the cycle out_valid drops.
REQ-031 Flags SHALL equal the classification of f by the team's hp_class decode whenever out_valid=1.

Reset
REQ-032 rst=1 at an edge SHALL force IDLE, out_valid=0, f=16'h0000, all six flags 0, regardless of state; an in-flight request is discarded.
REQ-033 While rst=1, in_ready SHALL be 0.

Verification
REQ-034 cls=0, mag=1, scale=0, sign=0 -> 15 shifts, f=0x3C00, normal=1, out_valid 18 cycles after accept.
REQ-035 cls=0, mag=65535, scale=0 -> f=0x7C00, infinity=1; mag=2049, scale=0 -> f=0x6800 (tie to even); mag=2051 -> f=0x6802.
REQ-036 cls=0, mag=1, scale=15, sign=1 -> 14 shifts, f=0x8200, subnormal=1; mag=0xFFFF, scale=15 -> f=0x4000 (rounds 1.99997 to 2.0), normal=1.
REQ-037 cls=4 payload=0 -> f=0x7C01 snan=1; cls=3 payload=0x1AB -> f=0x7FAB qnan=1; cls=6 -> f=0x7E00 qnan=1; cls=1 sign=1 -> f=0x8000 zero=1; all latency 1.
REQ-038 out_ready held 0 for 5 cycles in DONE -> f/flags stable, in_ready 0; in_valid held high -> next accept only after IDLE return.
REQ-039 rst pulsed during NORM of mag=1 request -> next cycle IDLE, out_valid=0, f=0, flags 0; fresh request completes correctly.
REQ-040 Random cls=0 sweep of all mag and scale, loopback through hp_class -> f matches reference RNE conversion, flags match hp_class outputs.
